// File: rtl/stack_pkg.sv
// Shared definitions for the stack-machine execution core.
//   op_e        : 4-bit command opcodes accepted on cmd_op
//   err_e       : sticky error cause reported on err_code
//   clog2_depth : width of a depth counter that can hold 0..DEPTH
package stack_pkg;

    typedef enum logic [3:0] {
        OP_NOP    = 4'h0,
        OP_PUSH   = 4'h1,
        OP_DROP   = 4'h2,
        OP_DUP    = 4'h3,
        OP_SWAP   = 4'h4,
        OP_OVER   = 4'h5,
        OP_ADD    = 4'h6,
        OP_SUB    = 4'h7,
        OP_AND    = 4'h8,
        OP_OR     = 4'h9,
        OP_XOR    = 4'hA,
        OP_NOT    = 4'hB,
        OP_MUL    = 4'hC,
        OP_CLRERR = 4'hD,
        OP_CLEAR  = 4'hE,
        OP_ILL    = 4'hF
    } op_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_UNDER   = 2'd1,
        ERR_OVER    = 2'd2,
        ERR_ILLEGAL = 2'd3
    } err_e;

    function automatic int clog2_depth(input int d);
        return $clog2(d + 1);
    endfunction

endpackage

// File: rtl/stack_mul_seq.sv
// Sequential shift-add multiplier, one partial product per clock.
// Operands are captured on the start edge; iterations run on the WIDTH
// following edges. done is asserted combinationally during the last
// iteration cycle so the caller can write prod on that same edge.
//   clk, rst : clock, asynchronous active-high reset (control only)
//   start    : load a/b and begin (ignored while busy)
//   a, b     : operands
//   busy     : multiply in progress
//   done     : final iteration this cycle, prod valid
//   prod     : low WIDTH bits of a*b
module stack_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] prod
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]    cnt_p0;
    logic [WIDTH-1:0] mcand_p0;
    logic [WIDTH-1:0] mplier_p0;
    logic [WIDTH-1:0] acc_p0;
    logic [WIDTH-1:0] acc_next;

    assign acc_next = acc_p0 + (mplier_p0[0] ? mcand_p0 : '0);
    assign done     = busy && (cnt_p0 == CW'(WIDTH - 1));
    assign prod     = acc_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy   <= 1'b0;
            cnt_p0 <= '0;
        end else if (start && !busy) begin
            busy   <= 1'b1;
            cnt_p0 <= '0;
        end else if (busy) begin
            if (done) busy <= 1'b0;
            else      cnt_p0 <= cnt_p0 + CW'(1);
        end
    end

    // Operand / accumulator stage: multiplicand shifts up, multiplier down.
    always_ff @(posedge clk) begin
        if (start && !busy) begin
            mcand_p0  <= a;
            mplier_p0 <= b;
            acc_p0    <= '0;
        end else if (busy) begin
            acc_p0    <= acc_next;
            mcand_p0  <= mcand_p0 << 1;
            mplier_p0 <= mplier_p0 >> 1;
        end
    end

endmodule

// File: rtl/stack_core_p.sv
// Parametrised stack-machine execution core.
// One command is accepted per cmd_valid & cmd_ready. Single-cycle ops
// update on the accepting edge; MUL runs WIDTH extra cycles in
// stack_mul_seq with cmd_ready held low.
//   clk, rst             : clock, asynchronous active-high reset
//   cmd_valid/ready      : command handshake (ready is registered only)
//   cmd_op, cmd_data     : opcode and PUSH immediate
//   top, next            : entries at depth-1 / depth-2, zero if absent
//   depth, empty, full   : occupancy
//   carry                : carry/borrow of the last ADD/SUB
//   busy                 : MUL in progress
//   err, err_code        : sticky error flag and first cause
module stack_core_p
    import stack_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [3:0]                 cmd_op,
    input  logic [WIDTH-1:0]           cmd_data,
    output logic [WIDTH-1:0]           top,
    output logic [WIDTH-1:0]           next,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       empty,
    output logic                       full,
    output logic                       carry,
    output logic                       busy,
    output logic                       err,
    output logic [1:0]                 err_code
);

    localparam int DW = clog2_depth(DEPTH);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] stack_q [DEPTH];
    logic [WIDTH-1:0] stack_d [DEPTH];
    logic [DW-1:0]    depth_q, depth_d;
    logic             carry_q, carry_d;
    logic             err_q;
    err_e             code_q;
    err_e             cause;
    logic             clr_err;
    logic             accept;
    logic             mul_start, mul_busy, mul_done;
    logic [WIDTH-1:0] mul_prod;
    logic [WIDTH:0]   wide;
    logic [AW-1:0]    ps, ti, ni;
    logic             has1, has2, is_full;
    logic [WIDTH-1:0] top_val, next_val;

    // Slot indices: ps = next free slot, ti = top, ni = next. Modulo-2^AW
    // arithmetic is harmless because each is only used when it is valid.
    assign ps = depth_q[AW-1:0];
    assign ti = ps - AW'(1);
    assign ni = ps - AW'(2);

    assign has1    = (depth_q != '0);
    assign has2    = (depth_q >= DW'(2));
    assign is_full = (depth_q == DW'(DEPTH));

    assign top_val  = has1 ? stack_q[ti] : '0;
    assign next_val = has2 ? stack_q[ni] : '0;

    assign cmd_ready = ~mul_busy;
    assign accept    = cmd_valid & cmd_ready;

    assign top      = top_val;
    assign next     = next_val;
    assign depth    = depth_q;
    assign empty    = ~has1;
    assign full     = is_full;
    assign carry    = carry_q;
    assign busy     = mul_busy;
    assign err      = err_q;
    assign err_code = code_q;

    stack_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (next_val),
        .b     (top_val),
        .busy  (mul_busy),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    always_comb begin
        stack_d   = stack_q;
        depth_d   = depth_q;
        carry_d   = carry_q;
        cause     = ERR_NONE;
        clr_err   = 1'b0;
        mul_start = 1'b0;
        wide      = '0;
        if (mul_done) begin
            stack_d[ni] = mul_prod;
            depth_d     = depth_q - DW'(1);
        end else if (accept) begin
            case (op_e'(cmd_op))
                OP_NOP: ;
                OP_PUSH: begin
                    if (is_full) cause = ERR_OVER;
                    else begin
                        stack_d[ps] = cmd_data;
                        depth_d     = depth_q + DW'(1);
                    end
                end
                OP_DROP: begin
                    if (!has1) cause = ERR_UNDER;
                    else       depth_d = depth_q - DW'(1);
                end
                OP_DUP: begin
                    if (!has1)        cause = ERR_UNDER;
                    else if (is_full) cause = ERR_OVER;
                    else begin
                        stack_d[ps] = top_val;
                        depth_d     = depth_q + DW'(1);
                    end
                end
                OP_SWAP: begin
                    if (!has2) cause = ERR_UNDER;
                    else begin
                        stack_d[ti] = next_val;
                        stack_d[ni] = top_val;
                    end
                end
                OP_OVER: begin
                    if (!has2)        cause = ERR_UNDER;
                    else if (is_full) cause = ERR_OVER;
                    else begin
                        stack_d[ps] = next_val;
                        depth_d     = depth_q + DW'(1);
                    end
                end
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                    if (!has2) cause = ERR_UNDER;
                    else begin
                        case (op_e'(cmd_op))
                            OP_ADD:  wide = {1'b0, next_val} + {1'b0, top_val};
                            OP_SUB:  wide = {1'b0, next_val} - {1'b0, top_val};
                            OP_AND:  wide = {1'b0, next_val & top_val};
                            OP_OR:   wide = {1'b0, next_val | top_val};
                            default: wide = {1'b0, next_val ^ top_val};
                        endcase
                        stack_d[ni] = wide[WIDTH-1:0];
                        depth_d     = depth_q - DW'(1);
                        // Bit WIDTH is carry for ADD and borrow for SUB.
                        if (op_e'(cmd_op) == OP_ADD || op_e'(cmd_op) == OP_SUB)
                            carry_d = wide[WIDTH];
                    end
                end
                OP_NOT: begin
                    if (!has1) cause = ERR_UNDER;
                    else       stack_d[ti] = ~top_val;
                end
                OP_MUL: begin
                    if (!has2) cause = ERR_UNDER;
                    else       mul_start = 1'b1;
                end
                OP_CLRERR: clr_err = 1'b1;
                OP_CLEAR:  depth_d = '0;
                default:   cause = ERR_ILLEGAL;
            endcase
            // A violating command leaves the stack untouched.
            if (cause != ERR_NONE) begin
                stack_d = stack_q;
                depth_d = depth_q;
                carry_d = carry_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
            depth_q <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            stack_q <= stack_d;
            depth_q <= depth_d;
            carry_q <= carry_d;
            if (clr_err) begin
                err_q  <= 1'b0;
                code_q <= ERR_NONE;
            end else if (cause != ERR_NONE && !err_q) begin
                // Only the first cause is recorded until cleared.
                err_q  <= 1'b1;
                code_q <= cause;
            end
        end
    end

endmodule

// File: tb/tb_stack_core_p.sv
module tb_stack_core_p;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [3:0]       cmd_op = 4'h0;
    logic [WIDTH-1:0] cmd_data = '0;
    logic [WIDTH-1:0] dut_top, dut_next;
    logic [2:0]       dut_depth;
    logic             dut_empty, dut_full, dut_carry, dut_busy, dut_err;
    logic [1:0]       dut_err_code;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] stk[$];
    bit         m_carry;
    bit         m_err;
    int         m_code;

    stack_core_p #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .top       (dut_top),
        .next      (dut_next),
        .depth     (dut_depth),
        .empty     (dut_empty),
        .full      (dut_full),
        .carry     (dut_carry),
        .busy      (dut_busy),
        .err       (dut_err),
        .err_code  (dut_err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        stk.delete();
        m_carry = 0;
        m_err   = 0;
        m_code  = 0;
    endfunction

    // Behavioural model: queue back is the top of stack.
    function automatic void model(input logic [3:0] op, input logic [7:0] d);
        int n = stk.size();
        int cause = 0;
        int t, s, r;
        case (op)
            4'h0: ;
            4'h1: if (n == DEPTH) cause = 2; else stk.push_back(d);
            4'h2: if (n < 1) cause = 1; else void'(stk.pop_back());
            4'h3: if (n < 1) cause = 1; else if (n == DEPTH) cause = 2; else stk.push_back(stk[n-1]);
            4'h4: if (n < 2) cause = 1; else begin
                      t = stk[n-1]; stk[n-1] = stk[n-2]; stk[n-2] = t[7:0];
                  end
            4'h5: if (n < 2) cause = 1; else if (n == DEPTH) cause = 2; else stk.push_back(stk[n-2]);
            4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hC: begin
                if (n < 2) cause = 1;
                else begin
                    t = stk.pop_back();
                    s = stk.pop_back();
                    case (op)
                        4'h6: begin r = s + t; m_carry = (r > 255); end
                        4'h7: begin r = s - t; m_carry = (s < t); end
                        4'h8: r = s & t;
                        4'h9: r = s | t;
                        4'hA: r = s ^ t;
                        default: r = s * t;
                    endcase
                    stk.push_back(r[7:0]);
                end
            end
            4'hB: if (n < 1) cause = 1; else stk[n-1] = ~stk[n-1];
            4'hD: begin m_err = 0; m_code = 0; end
            4'hE: stk.delete();
            default: cause = 3;
        endcase
        if (cause != 0 && !m_err) begin
            m_err  = 1;
            m_code = cause;
        end
    endfunction

    task automatic check_all(input string tag);
        int n = stk.size();
        chk({tag, ".top"},   dut_top,      (n >= 1) ? stk[n-1] : 8'h00);
        chk({tag, ".next"},  dut_next,     (n >= 2) ? stk[n-2] : 8'h00);
        chk({tag, ".depth"}, dut_depth,    n);
        chk({tag, ".empty"}, dut_empty,    n == 0);
        chk({tag, ".full"},  dut_full,     n == DEPTH);
        chk({tag, ".carry"}, dut_carry,    m_carry);
        chk({tag, ".err"},   dut_err,      m_err);
        chk({tag, ".code"},  dut_err_code, m_code);
        chk({tag, ".busy"},  dut_busy,     1'b0);
        chk({tag, ".ready"}, cmd_ready,    1'b1);
    endtask

    // Issue one command; for a started MUL, hold a junk PUSH valid while
    // busy and measure how many cycles cmd_ready stays low.
    task automatic send(input logic [3:0] op, input logic [7:0] d, input string tag);
        bit starts_mul;
        int lowc = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        starts_mul = (op == 4'hC) && (stk.size() >= 2);
        @(posedge clk);
        model(op, d);
        #1;
        if (starts_mul) begin
            cmd_op   = 4'h1;
            cmd_data = 8'hAA;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (cmd_ready === 1'b1) break;
                if (i == 0) chk({tag, ".busy_hi"}, dut_busy, 1'b1);
                lowc++;
            end
            cmd_valid = 1'b0;
            chk({tag, ".busy_cycles"}, lowc, WIDTH);
        end else begin
            cmd_valid = 1'b0;
            @(negedge clk);
        end
        check_all(tag);
    endtask

    initial begin
        logic [3:0] rop;
        logic [7:0] rdat;

        // Reset state
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst.depth", dut_depth, 3'd0);
        chk("rst.ready", cmd_ready, 1'b1);
        chk("rst.err",   dut_err,   1'b0);
        rst = 1'b0;
        check_all("rst");

        // ADD
        send(4'h1, 8'h12, "push12");
        send(4'h1, 8'h34, "push34");
        send(4'h6, 8'h00, "add");
        chk("add.top_lit", dut_top, 8'h46);
        chk("add.depth_lit", dut_depth, 3'd1);
        chk("add.carry_lit", dut_carry, 1'b0);

        // SUB with borrow, ADD with carry
        send(4'h1, 8'h05, "push05");
        send(4'h1, 8'h07, "push07");
        send(4'h7, 8'h00, "sub");
        chk("sub.top_lit", dut_top, 8'hFE);
        chk("sub.carry_lit", dut_carry, 1'b1);
        send(4'h1, 8'hFF, "pushFF");
        send(4'h1, 8'h01, "push01");
        send(4'h6, 8'h00, "add_wrap");
        chk("addw.top_lit", dut_top, 8'h00);
        chk("addw.carry_lit", dut_carry, 1'b1);

        // Overflow, then underflow with first error held
        send(4'hE, 8'h00, "clear");
        for (int i = 1; i <= 4; i++) send(4'h1, 8'(i), "fill");
        send(4'h1, 8'h05, "overflow");
        chk("ovf.code_lit", dut_err_code, 2'd2);
        chk("ovf.top_lit", dut_top, 8'h04);
        chk("ovf.depth_lit", dut_depth, 3'd4);
        for (int i = 0; i < 5; i++) send(4'h2, 8'h00, "drop");
        chk("under_held.code_lit", dut_err_code, 2'd2);
        send(4'hD, 8'h00, "clrerr");
        chk("clr.err_lit", dut_err, 1'b0);

        // MUL
        send(4'h1, 8'h0D, "push0D");
        send(4'h1, 8'h0B, "push0B");
        send(4'hC, 8'h00, "mul");
        chk("mul.top_lit", dut_top, 8'h8F);
        chk("mul.depth_lit", dut_depth, 3'd1);

        // Underflow and illegal
        send(4'hE, 8'h00, "clear2");
        send(4'h4, 8'h00, "swap_empty");
        chk("swap.code_lit", dut_err_code, 2'd1);
        send(4'hD, 8'h00, "clrerr2");
        send(4'hF, 8'h00, "illegal");
        chk("ill.code_lit", dut_err_code, 2'd3);
        send(4'hD, 8'h00, "clrerr3");
        send(4'hC, 8'h00, "mul_under");

        // Randomised ops against the model
        send(4'hD, 8'h00, "clrerr4");
        for (int k = 0; k < 250; k++) begin
            rop  = 4'($urandom_range(0, 15));
            rdat = 8'($urandom);
            if ($urandom_range(0, 3) == 0) rop = 4'h1;
            send(rop, rdat, "rand");
        end

        // Asynchronous reset during a MUL
        send(4'hE, 8'h00, "clear3");
        send(4'h1, 8'h03, "push03");
        send(4'h1, 8'h05, "push05b");
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 4'hC;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        model_reset();
        chk("arst.busy_lit", dut_busy, 1'b0);
        check_all("arst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send(4'h1, 8'h01, "post_rst_push");
        chk("prp.top_lit", dut_top, 8'h01);
        chk("prp.depth_lit", dut_depth, 3'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
